// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W   = 5;
   localparam int MUL_LAT_DEF = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MULTI    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   // Width of the multi-cycle down-counter; it must hold MUL_LAT-1.
   function automatic int cnt_width(input int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard comparator between the ID and EX stages.
module pipe_hazard_det
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] i_id_rs1,
   input  logic [REG_IDX_W-1:0] i_id_rs2,
   input  logic                 i_id_use_rs1,
   input  logic                 i_id_use_rs2,
   input  logic [REG_IDX_W-1:0] i_ex_rd,
   input  logic                 i_ex_is_load,
   output logic                 o_load_use
);

   logic w_hit_rs1;
   logic w_hit_rs2;

   // A load writing a real register (not x0) that the ID instruction reads.
   always_comb begin
      w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
      w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
      o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC / stage-register enables, flush and bubble
// generation for load-use, taken branches, multi-cycle EX ops and
// data-memory wait states, plus a saturating stall-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int STALL_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_load,
   input  logic                 ex_multi,
   input  logic                 ex_br_taken,
   input  logic                 mem_req,
   input  logic                 mem_ack,
   input  logic                 perf_clr,
   output logic                 pc_en,
   output logic                 en_ifid,
   output logic                 en_idex,
   output logic                 en_exmem,
   output logic                 en_memwb,
   output logic                 flush_ifid,
   output logic                 bubble_idex,
   output logic                 multi_done,
   output logic [1:0]           state,
   output logic [STALL_W-1:0]   stall_cnt
);

   localparam int CNT_W = cnt_width(MUL_LAT);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_skip_multi;
   logic               w_skip_nxt;
   logic [STALL_W-1:0] r_stall_cnt;

   logic w_freeze;
   logic w_load_use;
   logic w_pc_en;
   logic w_en_ifid;
   logic w_en_idex;
   logic w_en_exmem;
   logic w_en_memwb;
   logic w_flush_ifid;
   logic w_bubble_idex;
   logic w_multi_done;

   pipe_hazard_det u_hazard (
      .i_id_rs1     (id_rs1),
      .i_id_rs2     (id_rs2),
      .i_id_use_rs1 (id_use_rs1),
      .i_id_use_rs2 (id_use_rs2),
      .i_ex_rd      (ex_rd),
      .i_ex_is_load (ex_is_load),
      .o_load_use   (w_load_use)
   );

   assign w_freeze = mem_req & ~mem_ack;

   // Next-state, counter and enable decode; freeze silences every strobe.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_skip_nxt    = r_skip_multi;
      w_pc_en       = 1'b0;
      w_en_ifid     = 1'b0;
      w_en_idex     = 1'b0;
      w_en_exmem    = 1'b0;
      w_en_memwb    = 1'b0;
      w_flush_ifid  = 1'b0;
      w_bubble_idex = 1'b0;
      w_multi_done  = 1'b0;

      if (r_state == ST_MULTI) begin
         // The countdown keeps running through frozen cycles and parks at 0.
         w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
         if (!w_freeze) begin
            w_en_memwb = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
               w_multi_done = 1'b1;
               w_en_exmem   = 1'b1;
               w_en_idex    = 1'b1;
               w_state_nxt  = ST_RUN;
               w_skip_nxt   = 1'b1;
            end
         end
      end else if (w_freeze) begin
         w_state_nxt = ST_MEM_WAIT;
      end else begin
         // RUN, MEM_WAIT on its ack cycle, and the illegal encoding all decode as RUN.
         w_state_nxt = ST_RUN;
         w_skip_nxt  = 1'b0;
         w_pc_en     = 1'b1;
         w_en_ifid   = 1'b1;
         w_en_idex   = 1'b1;
         w_en_exmem  = 1'b1;
         w_en_memwb  = 1'b1;
         if (ex_br_taken) begin
            w_flush_ifid  = 1'b1;
            w_bubble_idex = 1'b1;
         end else if (ex_multi && !r_skip_multi) begin
            // The op just retired from MULTI must not be re-launched.
            w_en_exmem  = 1'b0;
            w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
            w_state_nxt = ST_MULTI;
         end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_en_ifid     = 1'b0;
            w_bubble_idex = 1'b1;
         end
      end
   end

   // Controller state, multi-cycle countdown and post-exit skip flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_cnt        <= '0;
         r_skip_multi <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_skip_multi <= w_skip_nxt;
      end
   end

   // Saturating count of cycles with the PC held; clear wins over increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (perf_clr) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_en && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign pc_en       = reset & w_pc_en;
   assign en_ifid     = reset & w_en_ifid;
   assign en_idex     = reset & w_en_idex;
   assign en_exmem    = reset & w_en_exmem;
   assign en_memwb    = reset & w_en_memwb;
   assign flush_ifid  = reset & w_flush_ifid;
   assign bubble_idex = reset & w_bubble_idex;
   assign multi_done  = reset & w_multi_done;
   assign state       = r_state;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl with a per-cycle expected-output scoreboard.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int SW = 5;
   localparam int ML = 4;
   localparam int OW = 8 + 2 + SW;

   // ctl bits: pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush, bubble, done
   localparam logic [7:0] NORM  = 8'b1111_1000;
   localparam logic [7:0] LU    = 8'b0011_1010;
   localparam logic [7:0] BR    = 8'b1111_1110;
   localparam logic [7:0] MENT  = 8'b1110_1000;
   localparam logic [7:0] MBUSY = 8'b0000_1000;
   localparam logic [7:0] MEXIT = 8'b0011_1001;
   localparam logic [7:0] FRZ   = 8'b0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_multi = 0;
   logic ex_br_taken = 0, mem_req = 0, mem_ack = 0, perf_clr = 0;
   logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
   logic flush_ifid, bubble_idex, multi_done;
   logic [1:0] state;
   logic [SW-1:0] stall_cnt;

   logic [OW-1:0] sb[$];
   logic [OW-1:0] got, want;
   int n_vec = 0;
   int n_bad = 0;

   pipe_ctrl #(.MUL_LAT(ML), .STALL_W(SW)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_multi(ex_multi), .ex_br_taken(ex_br_taken),
      .mem_req(mem_req), .mem_ack(mem_ack), .perf_clr(perf_clr),
      .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
      .en_memwb(en_memwb), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
      .multi_done(multi_done), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] pk(input logic [7:0] c, input logic [1:0] s, input int sc);
      return {c, s, SW'(sc)};
   endfunction

   function automatic logic [OW-1:0] obs();
      return {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex,
              multi_done, state, stall_cnt};
   endfunction

   task automatic idle_in();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_multi = 0;
      ex_br_taken = 0; mem_req = 0; mem_ack = 0; perf_clr = 0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cyc();
      next_cyc();
      idle_in();
      perf_clr = 1;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2);
      ex_is_load = 1; ex_rd = rd; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 4; c++) begin
         next_cyc();
         idle_in();
         if (c < 2) begin
            reset = 0; ex_multi = 1; id_use_rs1 = 1; ex_br_taken = 1;
            sb.push_back(pk(FRZ, ST_RUN, 0));
         end else begin
            reset = 1;
            sb.push_back(pk(NORM, ST_RUN, 0));
         end
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL reset c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_load_use();
      clr_cyc();
      for (int c = 0; c < 7; c++) begin
         next_cyc();
         idle_in();
         case (c)
            0: begin set_lu(5'd5, 5'd5, 1, 5'd0, 0); sb.push_back(pk(LU, ST_RUN, 0)); end
            1: sb.push_back(pk(NORM, ST_RUN, 1));
            2: begin set_lu(5'd7, 5'd3, 1, 5'd7, 1); sb.push_back(pk(LU, ST_RUN, 1)); end
            3: sb.push_back(pk(NORM, ST_RUN, 2));
            4: begin set_lu(5'd5, 5'd5, 0, 5'd5, 0); sb.push_back(pk(NORM, ST_RUN, 2)); end
            5: begin set_lu(5'd5, 5'd5, 1, 5'd0, 0); ex_is_load = 0;
                     sb.push_back(pk(NORM, ST_RUN, 2)); end
            default: begin set_lu(5'd9, 5'd4, 1, 5'd8, 1); sb.push_back(pk(NORM, ST_RUN, 2)); end
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL load_use c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_rd_zero();
      clr_cyc();
      for (int c = 0; c < 2; c++) begin
         next_cyc();
         idle_in();
         if (c == 0) set_lu(5'd0, 5'd0, 1, 5'd0, 1);
         sb.push_back(pk(NORM, ST_RUN, 0));
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL rd_zero c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_branch();
      clr_cyc();
      for (int c = 0; c < 3; c++) begin
         next_cyc();
         idle_in();
         case (c)
            0: begin set_lu(5'd5, 5'd5, 1, 5'd0, 0); ex_br_taken = 1; sb.push_back(pk(BR, ST_RUN, 0)); end
            1: begin ex_br_taken = 1; sb.push_back(pk(BR, ST_RUN, 0)); end
            default: sb.push_back(pk(NORM, ST_RUN, 0));
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL branch c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_multi();
      clr_cyc();
      for (int c = 0; c < 6; c++) begin
         next_cyc();
         idle_in();
         case (c)
            0: begin ex_multi = 1; sb.push_back(pk(MENT, ST_RUN, 0)); end
            1: sb.push_back(pk(MBUSY, ST_MULTI, 0));
            2: sb.push_back(pk(MBUSY, ST_MULTI, 1));
            3: sb.push_back(pk(MEXIT, ST_MULTI, 2));
            default: sb.push_back(pk(NORM, ST_RUN, 3));
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL multi c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clr_cyc();
      for (int c = 0; c < 10; c++) begin
         next_cyc();
         idle_in();
         ex_multi = (c < 6);
         case (c)
            0: sb.push_back(pk(MENT,  ST_RUN,   0));
            1: sb.push_back(pk(MBUSY, ST_MULTI, 0));
            2: sb.push_back(pk(MBUSY, ST_MULTI, 1));
            3: sb.push_back(pk(MEXIT, ST_MULTI, 2));
            4: sb.push_back(pk(NORM,  ST_RUN,   3));
            5: sb.push_back(pk(MENT,  ST_RUN,   3));
            6: sb.push_back(pk(MBUSY, ST_MULTI, 3));
            7: sb.push_back(pk(MBUSY, ST_MULTI, 4));
            8: sb.push_back(pk(MEXIT, ST_MULTI, 5));
            default: sb.push_back(pk(NORM, ST_RUN, 6));
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL back_to_back c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_multi_freeze();
      clr_cyc();
      for (int c = 0; c < 7; c++) begin
         next_cyc();
         idle_in();
         case (c)
            0: begin ex_multi = 1; sb.push_back(pk(MENT, ST_RUN, 0)); end
            1, 2, 3: begin mem_req = 1; sb.push_back(pk(FRZ, ST_MULTI, c - 1)); end
            4: begin mem_req = 1; mem_ack = 1; sb.push_back(pk(MEXIT, ST_MULTI, 3)); end
            default: sb.push_back(pk(NORM, ST_RUN, 4));
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL multi_freeze c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_mem_wait();
      clr_cyc();
      for (int c = 0; c < 4; c++) begin
         next_cyc();
         idle_in();
         case (c)
            0: begin mem_req = 1; set_lu(5'd5, 5'd5, 1, 5'd0, 0); sb.push_back(pk(FRZ, ST_RUN, 0)); end
            1: begin mem_req = 1; ex_br_taken = 1; sb.push_back(pk(FRZ, ST_MEM_WAIT, 1)); end
            2: begin mem_req = 1; mem_ack = 1; set_lu(5'd5, 5'd5, 1, 5'd0, 0);
                     sb.push_back(pk(LU, ST_MEM_WAIT, 2)); end
            default: sb.push_back(pk(NORM, ST_RUN, 3));
         endcase
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL mem_wait c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_saturate();
      clr_cyc();
      for (int c = 0; c < 43; c++) begin
         next_cyc();
         idle_in();
         if (c < 40) begin
            mem_req = 1;
            sb.push_back(pk(FRZ, (c == 0) ? ST_RUN : ST_MEM_WAIT, (c > 31) ? 31 : c));
         end else if (c == 40) begin
            mem_req = 1; perf_clr = 1;
            sb.push_back(pk(FRZ, ST_MEM_WAIT, 31));
         end else begin
            sb.push_back(pk(NORM, (c == 41) ? ST_MEM_WAIT : ST_RUN, 0));
         end
         @(negedge clk);
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL saturate c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   task automatic test_reset_mid_multi();
      clr_cyc();
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin
            // reset lands asynchronously in the middle of a MULTI cycle
            reset = 0;
            #1;
            sb.push_back(pk(FRZ, ST_RUN, 0));
         end else begin
            next_cyc();
            idle_in();
            reset = 1;
            case (c)
               0: begin ex_multi = 1; sb.push_back(pk(MENT, ST_RUN, 0)); end
               1: sb.push_back(pk(MBUSY, ST_MULTI, 0));
               2: sb.push_back(pk(MBUSY, ST_MULTI, 1));
               default: sb.push_back(pk(NORM, ST_RUN, 0));
            endcase
            @(negedge clk);
         end
         got = obs(); want = sb.pop_front(); n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL reset_mid_multi c%0d: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     c, got[OW-1 -: 8], got[SW+1 -: 2], got[SW-1:0],
                     want[OW-1 -: 8], want[SW+1 -: 2], want[SW-1:0]);
         end
      end
   endtask

   initial begin
      #2 reset = 0;
      test_reset();
      test_load_use();
      test_rd_zero();
      test_branch();
      test_multi();
      test_back_to_back();
      test_multi_freeze();
      test_mem_wait();
      test_saturate();
      test_reset_mid_multi();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
